// File: rtl/data_memory_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_pipe
//  Description : Byte-enabled, byte-addressed data memory with alignment and
//                range checking, a configurable read latency, a valid/ready
//                request port and a post-reset clearing sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_pipe #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [15:0]           test_value
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TOP_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  // Response pipeline: stage 0 captures at acceptance, stage RD_LATENCY drives the port
  logic [RD_LATENCY:0] pv_q, pv_d;
  logic [RD_LATENCY:0] pe_q, pe_d;
  logic [DATA_W-1:0]   pd_q [RD_LATENCY+1];
  logic [DATA_W-1:0]   pd_d [RD_LATENCY+1];

  logic               accept;
  logic               misaligned;
  logic               out_of_range;
  logic               addr_err;
  logic [IDX_W-1:0]   word_idx;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W-1:0]  merged;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [DATA_W-1:0]  mem_wdata;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign word_idx = req_addr[OFF_W +: IDX_W];

  generate
    if (OFF_W > 0) begin : g_align_chk
      assign misaligned = |req_addr[OFF_W-1:0];
    end else begin : g_no_align_chk
      assign misaligned = 1'b0;
    end

    if (TOP_W > 0) begin : g_range_chk
      assign out_of_range = |req_addr[ADDR_W-1:OFF_W+IDX_W];
    end else begin : g_no_range_chk
      assign out_of_range = 1'b0;
    end

    if (DATA_W >= 16) begin : g_tv_wide
      assign test_value = mem_q[0][15:0];
    end else begin : g_tv_narrow
      assign test_value = {{(16-DATA_W){1'b0}}, mem_q[0]};
    end
  endgenerate

  assign addr_err = misaligned | out_of_range;

  // Gated by rst so nothing is accepted or reported while reset is held
  assign req_ready = (state_q == ST_RUN) & ~rst;
  assign accept    = req_valid & req_ready;

  assign rd_word = mem_q[word_idx];

  // Next-state for the clearing sequencer: walk ptr across every word, then run
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      if (ptr_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Merge enabled write bytes over the current word and pick the memory write source
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < BE_W; i++) begin
      if (req_be[i]) begin
        merged[8*i +: 8] = req_wdata[8*i +: 8];
      end
    end
    mem_we    = 1'b0;
    mem_widx  = word_idx;
    mem_wdata = merged;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_we    = 1'b1;
        mem_widx  = ptr_q;
        mem_wdata = '0;
      end else if (accept && req_we && !addr_err) begin
        mem_we = 1'b1;
      end
    end
  end

  // Memory array; cleared by the sequencer rather than by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  // Response pipeline next-state: capture on accept, then shift one stage per cycle
  always_comb begin
    pv_d[0] = accept;
    pe_d[0] = accept & addr_err;
    pd_d[0] = (accept && !req_we && !addr_err) ? rd_word : '0;
    for (int i = 1; i <= RD_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  // Response pipeline registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q <= pv_d;
      pe_q <= pe_d;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        pd_q[i] <= pd_d[i];
      end
    end
  end

  assign rsp_valid = pv_q[RD_LATENCY] & ~rst;
  assign rsp_err   = pe_q[RD_LATENCY] & ~rst;
  assign rsp_rdata = rst ? '0 : pd_q[RD_LATENCY];

endmodule
`default_nettype wire

// File: tb/tb_data_memory_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_pipe
//  Description : Scoreboard bench for data_memory_pipe (DEPTH=256, latency 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_pipe;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [15:0]       test_value;

  data_memory_pipe #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .RD_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .test_value (test_value)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to timestamp expected responses
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   rsp_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response
  task automatic monitor_step();
    exp_t e;
    if (sb.size() != 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rsp: no response by cycle %0d expected at cycle %0d", cyc, e.due);
    end
    if (rsp_valid === 1'b1) begin
      rsp_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b expected no response (cycle %0d)",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.d);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
        check("rsp_cycle", cyc, e.due);
      end
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    check("req_ready_at_issue", {31'b0, req_ready}, 32'd1);
    sb.push_back('{exp_d, exp_e, cyc + 1 + LAT});
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   {31'b0, rsp_err}, 32'd0);
  endtask

  // Counts rising edges from the current point until req_ready is seen high
  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int snap;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // 1. Reset, clearing sequence length, read of word 0
    @(negedge clk);
    check_reset_outputs("rst1");
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("init_cycles", n, 256);
    check("test_value_after_init", {16'b0, test_value}, 32'd0);
    issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_0000, 1'b0);
    idle();
    drain();

    // 2. Byte-enable merge, read right after write
    issue(1'b1, 32'h10, 32'hAABB_CCDD, 4'b1111, 32'h0, 1'b0);
    issue(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0,         4'b0000, 32'hAA22_CC44, 1'b0);
    issue(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0,         4'b0000, 32'hAA22_CC44, 1'b0);
    idle();
    drain();

    // 3. Misaligned and out-of-range requests
    issue(1'b1, 32'h06,        32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b1);
    issue(1'b0, 32'h400,       32'h0,         4'b0000, 32'h0, 1'b1);
    issue(1'b1, 32'h8000_0010, 32'h5555_5555, 4'b1111, 32'h0, 1'b1);
    issue(1'b0, 32'h04,        32'h0,         4'b0000, 32'h0, 1'b0);
    issue(1'b0, 32'h10,        32'h0,         4'b0000, 32'hAA22_CC44, 1'b0);
    idle();
    drain();

    // 4. Back-to-back reads with latency 3
    issue(1'b1, 32'h04, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);
    issue(1'b1, 32'h08, 32'h9ABC_DEF0, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 32'h00, 32'h0, 4'b0000, 32'h0000_0000, 1'b0);
    issue(1'b0, 32'h04, 32'h0, 4'b0000, 32'h1234_5678, 1'b0);
    issue(1'b0, 32'h08, 32'h0, 4'b0000, 32'h9ABC_DEF0, 1'b0);
    idle();
    drain();

    // 5. test_value follows word 0
    issue(1'b1, 32'h00, 32'h0000_BEEF, 4'b1111, 32'h0, 1'b0);
    idle();
    check("test_value_beef", {16'b0, test_value}, 32'h0000_BEEF);
    drain();

    // 6a. Reset with reads in flight, memory re-cleared
    issue(1'b1, 32'h3FC, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 32'h3FC, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0);
    idle();
    drain();
    issue(1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0);
    issue(1'b0, 32'h00, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    sb.delete();
    snap = rsp_seen;
    @(negedge clk);
    check_reset_outputs("rst2");
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("init_cycles_after_rerst", n, 256);
    check("dropped_rsp_count", rsp_seen - snap, 0);
    check("test_value_recleared", {16'b0, test_value}, 32'd0);
    issue(1'b0, 32'h10,  32'h0, 4'b0000, 32'h0, 1'b0);
    issue(1'b0, 32'h3FC, 32'h0, 4'b0000, 32'h0, 1'b0);
    idle();
    drain();

    // 6b. Reset in the middle of the clearing sequence restarts it
    issue(1'b1, 32'h3FC, 32'h0BAD_CAFE, 4'b1111, 32'h0, 1'b0);
    idle();
    drain();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("init_cycles_restart", n, 256);
    issue(1'b0, 32'h3FC, 32'h0, 4'b0000, 32'h0, 1'b0);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
